// File: rtl/gshare_bp_assoc.sv
// rtl/gshare_bp_assoc.sv - gshare direction predictor with set-associative tagged BTB and repairable speculative history
`timescale 1ns/1ps
module gshare_bp_assoc #(
  parameter int XLEN     = 32,
  parameter int PHT_SIZE = 256,
  parameter int GHR_W    = 8,
  parameter int BTB_SIZE = 64,
  parameter int BTB_WAYS = 2,
  parameter int TAG_W    = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             fetch_valid_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic             ready_o,
  output logic             pred_taken_o,
  output logic [XLEN-1:0]  pred_target_o,
  output logic [GHR_W-1:0] pred_ghr_o,
  input  logic             upd_valid_i,
  input  logic [XLEN-1:0]  upd_pc_i,
  input  logic             upd_is_br_i,
  input  logic             upd_taken_i,
  input  logic [XLEN-1:0]  upd_target_i,
  input  logic [GHR_W-1:0] upd_ghr_i,
  input  logic             upd_mispredict_i
);

  localparam int PHT_IDX_W = $clog2(PHT_SIZE);
  localparam int BTB_SETS  = BTB_SIZE / BTB_WAYS;
  localparam int SET_W     = $clog2(BTB_SETS);
  localparam int WAY_W     = (BTB_WAYS > 1) ? $clog2(BTB_WAYS) : 1;
  // Sweep counter covers the larger of the two tables; both are powers of 2
  localparam int CNT_W     = (PHT_IDX_W > SET_W) ? PHT_IDX_W : SET_W;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [WAY_W-1:0] rr_q, rr_d;

  logic [1:0]       pht_q       [PHT_SIZE];
  logic             btb_valid_q [BTB_SETS][BTB_WAYS];
  logic [TAG_W-1:0] btb_tag_q   [BTB_SETS][BTB_WAYS];
  logic [XLEN-1:0]  btb_tgt_q   [BTB_SETS][BTB_WAYS];
  logic             btb_unc_q   [BTB_SETS][BTB_WAYS];

  logic                 run;
  logic [PHT_IDX_W-1:0] lk_idx, up_idx;
  logic [SET_W-1:0]     lk_set, up_set;
  logic [TAG_W-1:0]     lk_tag, up_tag;
  logic                 lk_hit, lk_unc, lk_dir;
  logic [XLEN-1:0]      lk_tgt;
  logic                 up_en, up_hit, up_free, btb_we, alloc;
  logic [WAY_W-1:0]     up_hit_way, up_free_way, up_way;
  logic [1:0]           up_ctr, up_ctr_nx;
  logic                 unused_bits;

  // Upper PC bits and the halfword-offset bit are not part of any index or tag
  assign unused_bits = ^{pc_i, upd_pc_i};

  assign run = (state_q == S_RUN) && !rst_i;

  assign lk_idx = pc_i[PHT_IDX_W:1] ^ PHT_IDX_W'(ghr_q);
  assign lk_set = pc_i[SET_W:1];
  assign lk_tag = pc_i[SET_W+TAG_W:SET_W+1];
  assign lk_dir = pht_q[lk_idx][1];

  assign up_idx = upd_pc_i[PHT_IDX_W:1] ^ PHT_IDX_W'(upd_ghr_i);
  assign up_set = upd_pc_i[SET_W:1];
  assign up_tag = upd_pc_i[SET_W+TAG_W:SET_W+1];
  assign up_ctr = pht_q[up_idx];

  // Fetch-side BTB tag compare; ways never hold duplicate tags, so OR-merging is safe
  always_comb begin
    lk_hit = 1'b0;
    lk_unc = 1'b0;
    lk_tgt = '0;
    for (int w = 0; w < BTB_WAYS; w++) begin
      if (btb_valid_q[lk_set][w] && (btb_tag_q[lk_set][w] == lk_tag)) begin
        lk_hit = 1'b1;
        lk_unc = btb_unc_q[lk_set][w];
        lk_tgt = btb_tgt_q[lk_set][w];
      end
    end
  end

  assign ready_o       = run;
  assign pred_taken_o  = run && fetch_valid_i && lk_hit && (lk_unc || lk_dir);
  assign pred_target_o = pred_taken_o ? lk_tgt : '0;
  assign pred_ghr_o    = run ? ghr_q : '0;

  // Update-side way selection: tag hit first, else lowest free way, else round-robin victim
  always_comb begin
    up_hit      = 1'b0;
    up_hit_way  = '0;
    up_free     = 1'b0;
    up_free_way = '0;
    for (int w = 0; w < BTB_WAYS; w++) begin
      if (btb_valid_q[up_set][w] && (btb_tag_q[up_set][w] == up_tag)) begin
        up_hit     = 1'b1;
        up_hit_way = WAY_W'(w);
      end
      if (!btb_valid_q[up_set][w] && !up_free) begin
        up_free     = 1'b1;
        up_free_way = WAY_W'(w);
      end
    end
    up_way = up_hit ? up_hit_way : (up_free ? up_free_way : rr_q);
  end

  assign up_en  = run && upd_valid_i;
  assign btb_we = up_en && upd_taken_i;
  assign alloc  = btb_we && !up_hit;

  // Saturating 2-bit counter step
  always_comb begin
    up_ctr_nx = up_ctr;
    if (upd_taken_i) begin
      if (up_ctr != 2'b11) up_ctr_nx = up_ctr + 2'b01;
    end else begin
      if (up_ctr != 2'b00) up_ctr_nx = up_ctr - 2'b01;
    end
  end

  // Next-state: init sweep, history repair/speculation, replacement pointer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ghr_d   = ghr_q;
    rr_d    = rr_q;
    case (state_q)
      S_INIT: begin
        if (cnt_q == '1) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        // Repair takes priority: the speculative path it would shift is already wrong
        if (upd_valid_i && upd_mispredict_i) begin
          ghr_d = upd_is_br_i ? {upd_ghr_i[GHR_W-2:0], upd_taken_i} : upd_ghr_i;
        end else if (fetch_valid_i && !stall_i && lk_hit && !lk_unc) begin
          ghr_d = {ghr_q[GHR_W-2:0], lk_dir};
        end
        if (alloc) begin
          rr_d = (rr_q == WAY_W'(BTB_WAYS - 1)) ? '0 : rr_q + 1'b1;
        end
      end
    endcase
  end

  // Control state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      ghr_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ghr_q   <= ghr_d;
      rr_q    <= rr_d;
    end
  end

  // Table writes: init sweep in INIT, resolved-branch training in RUN
  always_ff @(posedge clk_i) begin
    if (!rst_i && (state_q == S_INIT)) begin
      if (32'(cnt_q) < PHT_SIZE) pht_q[cnt_q[PHT_IDX_W-1:0]] <= 2'b01;
      if (32'(cnt_q) < BTB_SETS) begin
        for (int w = 0; w < BTB_WAYS; w++) btb_valid_q[cnt_q[SET_W-1:0]][w] <= 1'b0;
      end
    end else if (up_en) begin
      if (upd_is_br_i) pht_q[up_idx] <= up_ctr_nx;
      if (btb_we) begin
        btb_valid_q[up_set][up_way] <= 1'b1;
        btb_tag_q[up_set][up_way]   <= up_tag;
        btb_tgt_q[up_set][up_way]   <= upd_target_i;
        btb_unc_q[up_set][up_way]   <= !upd_is_br_i;
      end
    end
  end

endmodule
